// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
//   Shared definitions for the interrupt controller.
//   - irq_state_t : handshake FSM states (IDLE -> REQ -> ACTIVE -> IDLE)
//   - IRQ_TIMER / IRQ_EBREAK / IRQ_BUSERROR : reserved channel numbers
//   - NUM_RESERVED : count of reserved low channels (their irq_in bits unused)
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } irq_state_t;

  localparam int IRQ_TIMER    = 0;
  localparam int IRQ_EBREAK   = 1;
  localparam int IRQ_BUSERROR = 2;
  localparam int NUM_RESERVED = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
//   Combinational lowest-index-first priority encoder.
//   Ports:
//     i_req   [NUM_IRQ] : request vector
//     o_valid           : at least one request bit set
//     o_idx   [ID_W]    : index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int NUM_IRQ = 32,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_idx
);

  logic [ID_W-1:0] w_idx;

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    w_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_idx = ID_W'(i);
      end
    end
  end

  assign o_valid = |i_req;
  assign o_idx   = w_idx;

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//   Parametrised interrupt controller with a req/ack/done handshake to the core.
//   Channel 0 = countdown timer, 1 = ebreak, 2 = bus error; channels 3.. come
//   from irq_in and are edge or level sensitive per LEVEL_MODE.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     irq_in                   : external lines (bits 0..2 ignored)
//     irq_ebreak, irq_buserror : one-cycle pulses setting pending[1] / [2]
//     mask_we, mask_wdata      : mask register write (1 = disabled)
//     timer_we, timer_wdata    : timer load (0 cancels without firing)
//     irq_req, irq_id          : request and id presented to the core
//     irq_ack, irq_done        : core accepts request / returns from handler
//     irq_active               : handler in progress
//     irq_mask, irq_pending    : current mask / pending state
//     eoi                      : one-hot of the channel being serviced
//     timer                    : current timer value
// -----------------------------------------------------------------------------
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ     = 32,
  parameter int                 TIMER_WIDTH = 32,
  parameter logic [NUM_IRQ-1:0] LEVEL_MODE  = '0,
  parameter int                 ID_W        = $clog2(NUM_IRQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic                   irq_ebreak,
  input  logic                   irq_buserror,
  input  logic                   mask_we,
  input  logic [NUM_IRQ-1:0]     mask_wdata,
  input  logic                   timer_we,
  input  logic [TIMER_WIDTH-1:0] timer_wdata,
  output logic                   irq_req,
  output logic [ID_W-1:0]        irq_id,
  input  logic                   irq_ack,
  input  logic                   irq_done,
  output logic                   irq_active,
  output logic [NUM_IRQ-1:0]     irq_mask,
  output logic [NUM_IRQ-1:0]     irq_pending,
  output logic [NUM_IRQ-1:0]     eoi,
  output logic [TIMER_WIDTH-1:0] timer
);

  // Reserved channels never take irq_in and are always edge (sticky) channels.
  localparam logic [NUM_IRQ-1:0] RSVD_BITS = NUM_IRQ'((1 << NUM_RESERVED) - 1);
  localparam logic [NUM_IRQ-1:0] LEVEL_EFF = LEVEL_MODE & ~RSVD_BITS;

  irq_state_t               r_state;
  logic                     r_req;
  logic [ID_W-1:0]          r_id;
  logic                     r_active;
  logic [NUM_IRQ-1:0]       r_eoi;
  logic [NUM_IRQ-1:0]       r_mask;
  logic [NUM_IRQ-1:0]       r_pending;
  logic [NUM_IRQ-1:0]       r_irq_prev;
  logic [TIMER_WIDTH-1:0]   r_timer;

  logic [NUM_IRQ-1:0]       w_irq_ext;
  logic [NUM_IRQ-1:0]       w_rise;
  logic [NUM_IRQ-1:0]       w_int_set;
  logic [NUM_IRQ-1:0]       w_set;
  logic [NUM_IRQ-1:0]       w_clr;
  logic [NUM_IRQ-1:0]       w_pending_next;
  logic [NUM_IRQ-1:0]       w_eligible;
  logic [NUM_IRQ-1:0]       w_id_onehot;
  logic                     w_timer_fire;
  logic                     w_enc_valid;
  logic [ID_W-1:0]          w_enc_idx;
  logic                     w_accept;

  // External lines with the reserved positions forced low.
  assign w_irq_ext = irq_in & ~RSVD_BITS;
  assign w_rise    = w_irq_ext & ~r_irq_prev;

  // A load in the same cycle as 1 -> 0 replaces the expiry, so no fire.
  assign w_timer_fire = ~timer_we & (r_timer == TIMER_WIDTH'(1));

  always_comb begin
    w_int_set               = '0;
    w_int_set[IRQ_TIMER]    = w_timer_fire;
    w_int_set[IRQ_EBREAK]   = irq_ebreak;
    w_int_set[IRQ_BUSERROR] = irq_buserror;
  end

  assign w_set       = w_rise | w_int_set;
  assign w_id_onehot = NUM_IRQ'(1) << r_id;
  assign w_accept    = (r_state == ST_REQ) && irq_ack;
  assign w_clr       = w_accept ? (w_id_onehot & ~LEVEL_EFF) : '0;

  // Edge channels: sticky, set beats clear. Level channels: mirror the line.
  assign w_pending_next = (LEVEL_EFF & w_irq_ext)
                        | (~LEVEL_EFF & ((r_pending & ~w_clr) | w_set));

  assign w_eligible = r_pending & ~r_mask;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .i_req   (w_eligible),
    .o_valid (w_enc_valid),
    .o_idx   (w_enc_idx)
  );

  // Pending, mask, edge history and timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_mask     <= '1;
      r_irq_prev <= '0;
      r_timer    <= '0;
    end else begin
      r_pending  <= w_pending_next;
      r_irq_prev <= w_irq_ext;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
      if (timer_we) begin
        r_timer <= timer_wdata;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - TIMER_WIDTH'(1);
      end
    end
  end

  // Handshake FSM. irq_id is latched on entry to REQ and held until the
  // next request, so mask/pending changes cannot disturb a presented request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_req    <= 1'b0;
      r_id     <= '0;
      r_active <= 1'b0;
      r_eoi    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_enc_valid) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_id    <= w_enc_idx;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            r_state  <= ST_ACTIVE;
            r_req    <= 1'b0;
            r_active <= 1'b1;
            r_eoi    <= w_id_onehot;
          end
        end
        ST_ACTIVE: begin
          if (irq_done) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_eoi    <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_req     = r_req;
  assign irq_id      = r_id;
  assign irq_active  = r_active;
  assign irq_mask    = r_mask;
  assign irq_pending = r_pending;
  assign eoi         = r_eoi;
  assign timer       = r_timer;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller between external IRQ lines and the CPU core. It replaces the fixed 32-line irq/mask/pending/timer logic.
- Generalised in channel count, per-channel edge/level mode and timer width.
- Adds a req/ack/done handshake to the core, plus per-channel end-of-interrupt (eoi) reporting.
- Channels 0/1/2 are reserved for timer, ebreak and bus error.

Parameters:
NUM_IRQ, 32, number of interrupt channels (>= 3)
TIMER_WIDTH, 32, width of the countdown timer
LEVEL_MODE, all zeros (NUM_IRQ bits), per channel: 1 = level-sensitive, 0 = rising-edge
ID_W, $clog2(NUM_IRQ), width of the interrupt id

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
irq_in  in  NUM_IRQ  external lines, synchronous to clk; bits 0..2 are ignored
irq_ebreak  in  1  one-cycle pulse, sets pending[1]
irq_buserror  in  1  one-cycle pulse, sets pending[2]
mask_we  in  1  write enable for the mask register
mask_wdata  in  NUM_IRQ  new mask value (1 = channel disabled)
timer_we  in  1  write enable for the timer
timer_wdata  in  TIMER_WIDTH  new timer value
irq_req  out  1  interrupt request to the core
irq_id  out  ID_W  id of the requested/active channel
irq_ack  in  1  core accepts the request
irq_done  in  1  core returns from the handler
irq_active  out  1  handler in progress
irq_mask  out  NUM_IRQ  current mask
irq_pending  out  NUM_IRQ  current pending bits
eoi  out  NUM_IRQ  one-hot bit of the channel being serviced
timer  out  TIMER_WIDTH  current timer value

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - irq_req = 0, irq_id = 0, irq_active = 0, irq_pending = 0, eoi = 0, timer = 0.
  - irq_mask = all ones (every channel disabled).
  - Edge-detect history register = 0.
  - FSM state = IDLE.
  - Reset asserted mid-handshake aborts it: no eoi pulse, the core sees irq_req/irq_active drop on the next cycle.
- Edge channels:
  - pending[i] is set in the cycle after irq_in[i] is sampled 1 while its previous sample was 0.
  - The bit stays set until it is serviced.
- Level channels: pending[i] is the registered value of irq_in[i], not sticky. It is never cleared by service.
- Internal sources: irq_ebreak and irq_buserror set pending[1] and pending[2] one cycle later. Bits 1 and 2 are always treated as edge channels.
- Timer:
  - If timer != 0, it decrements by 1 every cycle.
  - On the 1 -> 0 transition, pending[0] is set in the same edge. A timer at 0 stays at 0.
  - timer_we overrides the decrement in that cycle. Writing 0 cancels the timer without firing.
- Set/clear collision: if a pending bit is set and cleared in the same cycle, set wins, so no event is lost.
- Eligible channels are pending & ~mask. Lowest index has highest priority.
- FSM states are IDLE, REQ and ACTIVE:
  - IDLE: if any channel is eligible, go to REQ. Latch irq_id = lowest eligible index and assert irq_req on the next edge. The latency from pending set to irq_req is 1 cycle.
  - REQ: irq_req and irq_id are held stable until irq_ack, even if the mask or pending bits change. When irq_ack = 1:
    - go to ACTIVE and drop irq_req;
    - set irq_active = 1;
    - set eoi = 1 << irq_id;
    - clear pending[irq_id] if that channel is edge mode.
  - ACTIVE: no new request is issued, so there is no nesting. When irq_done = 1: clear eoi and irq_active, then return to IDLE. A new request can be raised 1 cycle after IDLE is re-entered.
- irq_ack outside REQ and irq_done outside ACTIVE are ignored.
- mask_we takes effect on the next edge. Masking a channel while in ACTIVE has no effect on the current handler.

Decomposition:
- Package irq_ctrl_pkg holds:
  - the FSM state enum (IDLE, REQ, ACTIVE);
  - the constants IRQ_TIMER = 0, IRQ_EBREAK = 1, IRQ_BUSERROR = 2.
- One sub-module, irq_prio_enc: a combinational, parametrised lowest-index-first priority encoder over NUM_IRQ bits. It produces a valid flag and an ID_W-bit index.

Test Plan:
- Reset then idle:
  - Check irq_mask = 0xFFFFFFFF and every other output = 0.
  - Pulse irq_in[5] while masked: pending[5] = 1, irq_req stays 0.
- mask_wdata = 0xFFFFFFDF, rising edge on irq_in[5]:
  - pending[5] = 1 at cycle +1 and irq_req = 1, irq_id = 5 at cycle +2.
  - After irq_ack: eoi = 0x20, irq_active = 1, pending[5] = 0.
  - After irq_done: eoi = 0, irq_active = 0.
- Priority: mask = 0, assert irq_in[9] and irq_in[4] in the same cycle.
  - irq_id = 4 first.
  - After ack and done, irq_id = 9 is requested.
- Timer: timer_wdata = 3 with mask = 0.
  - timer reads 2, 1, 0; pending[0] sets on reaching 0; irq_id = 0.
  - Rewriting timer = 0 before expiry produces no interrupt.
- Level channel (LEVEL_MODE[7] = 1), irq_in[7] held high through ack/done:
  - pending[7] stays 1 and the channel re-requests 1 cycle after IDLE.
  - Dropping irq_in[7] clears pending[7] 1 cycle later.
- Collisions:
  - irq_buserror pulse in the same cycle as irq_ack for id 2: pending[2] remains 1.
  - rst asserted in REQ: next cycle irq_req = 0, eoi = 0, state IDLE.
